// File: rtl/conv_pkg.sv
// Shared parameters, FSM states and pixel payload types for the convolution window reader.
// Window addressing is kept here so the reader and any checker use one formula.
package conv_pkg;

    localparam int unsigned IMG_W     = 9;
    localparam int unsigned IMG_H     = 9;
    localparam int unsigned K         = 3;
    localparam int unsigned STRIDE    = 2;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;

    localparam int unsigned OUT_W     = (IMG_W - K) / STRIDE + 1;
    localparam int unsigned OUT_H     = (IMG_H - K) / STRIDE + 1;
    localparam int unsigned BUF_DEPTH = IMG_W * IMG_H;

    localparam int unsigned KC_W      = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned OC_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE
    } state_t;

    typedef struct packed {
        logic first;
        logic last;
        logic img_last;
    } px_tag_t;

    typedef struct packed {
        px_tag_t             tag;
        logic [DATA_W-1:0]   data;
    } px_word_t;

    // Address of tap (kr,kc) of output window (orow,ocol) in the selected ping-pong buffer.
    function automatic logic [ADDR_W-1:0] win_addr(
        input logic            sel,
        input logic [OC_W-1:0] orow,
        input logic [OC_W-1:0] ocol,
        input logic [KC_W-1:0] kr,
        input logic [KC_W-1:0] kc
    );
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        base = sel ? ADDR_W'(BUF_DEPTH) : '0;
        row  = ADDR_W'(orow) * ADDR_W'(STRIDE) + ADDR_W'(kr);
        col  = ADDR_W'(ocol) * ADDR_W'(STRIDE) + ADDR_W'(kc);
        return base + row * ADDR_W'(IMG_W) + col;
    endfunction

endpackage

// File: rtl/conv_window_reader_if.sv
// Image handshake, RAM read port and window pixel stream of the convolution window reader.
interface conv_window_reader_if;

    logic                          img_ready;
    logic                          img_release;
    logic [conv_pkg::ADDR_W-1:0]   rAddr;
    logic                          rd_en;
    logic [conv_pkg::DATA_W-1:0]   ram_rdata;
    logic                          px_valid;
    logic                          px_ready;
    logic [conv_pkg::DATA_W-1:0]   px_data;
    logic                          px_first;
    logic                          px_last;
    logic                          px_img_last;

    modport master (
        input  img_ready, ram_rdata, px_ready,
        output img_release, rAddr, rd_en, px_valid, px_data, px_first, px_last, px_img_last
    );

    modport slave (
        output img_ready, ram_rdata, px_ready,
        input  img_release, rAddr, rd_en, px_valid, px_data, px_first, px_last, px_img_last
    );

endinterface

// File: rtl/pixel_skid_fifo.sv
// Two-entry fall-through FIFO for tagged pixels; an arriving word is visible the same cycle
// when the FIFO is empty, which gives one cycle from read issue to px_valid.
module pixel_skid_fifo
    import conv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  px_word_t push_word,
    input  logic     pop,
    output logic     out_valid,
    output px_word_t out_word,
    output logic [1:0] count
);

    px_word_t mem [2];
    logic     wr_ptr;
    logic     rd_ptr;
    logic     empty;
    logic     store;
    logic     take;

    // An arriving word consumed in the same cycle while empty never gets stored.
    assign empty     = (count == 2'd0);
    assign store     = push && !(empty && pop);
    assign take      = pop && !empty;
    assign out_valid = !empty || push;

    always_comb begin
        out_word = '0;
        if (!empty) begin
            out_word = mem[rd_ptr];
        end else if (push) begin
            out_word = push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) wr_ptr <= ~wr_ptr;
            if (take)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(store) - 2'(take);
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= push_word;
    end

endmodule

// File: rtl/conv_window_reader.sv
// Walks KxK windows at STRIDE over a ping-pong image buffer, issues RAM reads and streams
// tagged window pixels through a small output FIFO with credit-based read throttling.
module conv_window_reader
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    conv_window_reader_if.master  bus
);

    state_t             state;
    logic               buf_sel;
    logic [KC_W-1:0]    kc;
    logic [KC_W-1:0]    kr;
    logic [OC_W-1:0]    ocol;
    logic [OC_W-1:0]    orow;

    logic [ADDR_W-1:0]  raddr;
    logic               rd_en;
    px_tag_t            rd_tag;
    logic               arr;
    px_tag_t            arr_tag;
    logic               img_release;

    logic               fifo_valid;
    px_word_t           fifo_word;
    logic [1:0]         fifo_count;
    px_word_t           push_word;
    logic               pop;
    logic [2:0]         pending;
    logic               issue;
    px_tag_t            cur_tag;

    // Reads in flight plus words held after this cycle's pop must leave room for one more.
    assign pop     = fifo_valid && bus.px_ready;
    assign pending = 3'(rd_en) + 3'(arr) + 3'(fifo_count) - 3'(pop);
    assign issue   = (pending < 3'd2) &&
                     ((state == READ) || ((state == IDLE) && bus.img_ready));

    assign cur_tag.first    = (kc == '0) && (kr == '0);
    assign cur_tag.last     = (kc == KC_W'(K - 1)) && (kr == KC_W'(K - 1));
    assign cur_tag.img_last = cur_tag.last && (ocol == OC_W'(OUT_W - 1)) &&
                              (orow == OC_W'(OUT_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            buf_sel     <= 1'b0;
            kc          <= '0;
            kr          <= '0;
            ocol        <= '0;
            orow        <= '0;
            raddr       <= '0;
            rd_en       <= 1'b0;
            rd_tag      <= '0;
            arr         <= 1'b0;
            arr_tag     <= '0;
            img_release <= 1'b0;
        end else begin
            arr         <= rd_en;
            arr_tag     <= rd_tag;
            rd_en       <= issue;
            img_release <= 1'b0;

            if (issue) begin
                raddr  <= win_addr(buf_sel, orow, ocol, kr, kc);
                rd_tag <= cur_tag;
                if (kc == KC_W'(K - 1)) begin
                    kc <= '0;
                    if (kr == KC_W'(K - 1)) begin
                        kr <= '0;
                        if (ocol == OC_W'(OUT_W - 1)) begin
                            ocol <= '0;
                            orow <= (orow == OC_W'(OUT_H - 1)) ? '0 : orow + 1'b1;
                        end else begin
                            ocol <= ocol + 1'b1;
                        end
                    end else begin
                        kr <= kr + 1'b1;
                    end
                end else begin
                    kc <= kc + 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.img_ready) state <= READ;
                end
                READ: begin
                    if (issue && cur_tag.img_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && fifo_word.tag.img_last) begin
                        state       <= RELEASE;
                        img_release <= 1'b1;
                    end
                end
                RELEASE: begin
                    buf_sel <= ~buf_sel;
                    kc      <= '0;
                    kr      <= '0;
                    ocol    <= '0;
                    orow    <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push_word.tag  = arr_tag;
    assign push_word.data = bus.ram_rdata;

    pixel_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (arr),
        .push_word (push_word),
        .pop       (pop),
        .out_valid (fifo_valid),
        .out_word  (fifo_word),
        .count     (fifo_count)
    );

    assign bus.rAddr       = raddr;
    assign bus.rd_en       = rd_en;
    assign bus.img_release = img_release;
    assign bus.px_valid    = fifo_valid;
    assign bus.px_data     = fifo_word.data;
    assign bus.px_first    = fifo_word.tag.first;
    assign bus.px_last     = fifo_word.tag.last;
    assign bus.px_img_last = fifo_word.tag.img_last;

endmodule

// File: tb/tb_conv_window_reader.sv
// Scoreboard bench for conv_window_reader: expected addresses and tagged pixels are queued
// when an image is armed and compared as the reader issues reads and the sink accepts pixels.
module tb_conv_window_reader;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    conv_window_reader_if bus ();

    conv_window_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int exp_addr [$];
    int exp_px   [$];
    int addr_log [$];
    int rel_cyc  [$];
    int rel_cnt;
    int px_in_img;
    int first_rd_cyc;
    int first_pv_cyc;
    int last_acc_cyc;
    int ready_mode;
    logic stalled_prev;
    int   prev_word;
    logic prev_rel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ram_val(input int a);
        return 8'((a * 37 + 11) ^ (a >> 2));
    endfunction

    // Reference traversal written directly from the window geometry (9x9 image, 3x3, stride 2).
    task automatic push_image(input int sel);
        int i;
        int a;
        i = 0;
        for (int orow = 0; orow < 4; orow++)
            for (int ocol = 0; ocol < 4; ocol++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        a = sel * 81 + (orow * 2 + kr) * 9 + ocol * 2 + kc;
                        exp_addr.push_back(a);
                        exp_px.push_back(int'({ram_val(a), (i % 9) == 0, (i % 9) == 8, i == 143}));
                        i++;
                    end
    endtask

    task automatic wait_release(input int target, input int budget);
        int n;
        n = 0;
        while (rel_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("release_seen", int'(rel_cnt >= target), 1);
    endtask

    // Synchronous RAM model: data for the address issued last cycle, noise otherwise.
    always @(posedge clk) begin
        if (bus.rd_en) bus.ram_rdata <= ram_val(int'(bus.rAddr));
        else           bus.ram_rdata <= 8'($urandom);
    end

    initial begin
        bus.px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.px_ready = 1'b0;
                1:       bus.px_ready = 1'b1;
                default: bus.px_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        int word;
        if (!reset) begin
            word = int'({bus.px_valid, bus.px_data, bus.px_first, bus.px_last, bus.px_img_last});
            if (bus.rd_en) begin
                addr_log.push_back(int'(bus.rAddr));
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check_eq("addr_q_nonempty", int'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) check_eq("raddr", int'(bus.rAddr), exp_addr.pop_front());
            end
            if (bus.px_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
            if (stalled_prev) check_eq("stall_hold", word, prev_word);
            if (bus.px_valid && bus.px_ready) begin
                check_eq("px_q_nonempty", int'(exp_px.size() > 0), 1);
                if (exp_px.size() > 0) check_eq("px_word", word & 16'h7FF, exp_px.pop_front());
                px_in_img++;
                if (bus.px_img_last) last_acc_cyc = cyc;
            end
            if (bus.img_release) begin
                check_eq("rel_px_cnt", px_in_img, 144);
                check_eq("rel_one_cycle", int'(prev_rel), 0);
                px_in_img = 0;
                rel_cnt++;
                rel_cyc.push_back(cyc);
            end
            stalled_prev = bus.px_valid && !bus.px_ready;
            prev_word    = word;
            prev_rel     = bus.img_release;
        end else begin
            stalled_prev = 1'b0;
            prev_rel     = 1'b0;
        end
    end

    task automatic check_outputs_clear(input string pfx);
        check_eq({pfx, "_rd_en"},       int'(bus.rd_en), 0);
        check_eq({pfx, "_raddr"},       int'(bus.rAddr), 0);
        check_eq({pfx, "_px_valid"},    int'(bus.px_valid), 0);
        check_eq({pfx, "_px_data"},     int'(bus.px_data), 0);
        check_eq({pfx, "_tags"},        int'({bus.px_first, bus.px_last, bus.px_img_last}), 0);
        check_eq({pfx, "_img_release"}, int'(bus.img_release), 0);
    endtask

    initial begin
        int first_w [9];
        int last_w  [9];
        int rel_before;
        int n;
        first_w = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
        last_w  = '{60, 61, 62, 69, 70, 71, 78, 79, 80};
        checks = 0; failures = 0; cyc = 0; rel_cnt = 0; px_in_img = 0;
        first_rd_cyc = -1; first_pv_cyc = -1; last_acc_cyc = -1;
        stalled_prev = 1'b0; prev_word = 0; prev_rel = 1'b0;
        ready_mode = 1;
        reset = 1'b1;
        bus.img_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_clear("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Buffer 0 with an always-ready sink: geometry, latency and full throughput.
        repeat (2) @(posedge clk);
        #1;
        addr_log.delete();
        first_rd_cyc = -1; first_pv_cyc = -1;
        push_image(0);
        bus.img_ready = 1'b1;
        wait_release(1, 1000);
        bus.img_ready = 1'b0;
        check_eq("a_nreads", addr_log.size(), 144);
        if (addr_log.size() == 144)
            for (int i = 0; i < 9; i++) begin
                check_eq("a_first_win", addr_log[i], first_w[i]);
                check_eq("a_last_win", addr_log[135 + i], last_w[i]);
            end
        check_eq("a_latency", first_pv_cyc - first_rd_cyc, 1);
        check_eq("a_throughput", last_acc_cyc - first_pv_cyc, 143);
        repeat (10) @(posedge clk);
        #1;
        check_eq("a_rel_cnt", rel_cnt, 1);

        // Buffer 1 with a random sink; img_ready drops mid-image and must be ignored.
        addr_log.delete();
        ready_mode = 2;
        push_image(1);
        bus.img_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 bus.img_ready = 1'b0;
        wait_release(2, 3000);
        check_eq("b_nreads", addr_log.size(), 144);
        if (addr_log.size() == 144) begin
            check_eq("b_first_addr", addr_log[0], 81);
            check_eq("b_last_addr", addr_log[143], 161);
        end
        repeat (5) @(posedge clk);
        #1;

        // Two back-to-back images with img_ready held high.
        addr_log.delete();
        ready_mode = 1;
        push_image(0);
        push_image(1);
        bus.img_ready = 1'b1;
        wait_release(4, 2000);
        bus.img_ready = 1'b0;
        check_eq("c_nreads", addr_log.size(), 288);
        if (addr_log.size() == 288) begin
            check_eq("c_first_addr", addr_log[0], 0);
            check_eq("c_img1_first", addr_log[144], 81);
            check_eq("c_img1_last", addr_log[287], 161);
        end
        if (rel_cyc.size() >= 4) check_eq("c_rel_gap", int'(rel_cyc[3] - rel_cyc[2] >= 144), 1);
        check_eq("c_px_q_empty", exp_px.size(), 0);
        repeat (5) @(posedge clk);
        #1;

        // Reset at read 70 of an image, then a clean re-run of buffer 0.
        addr_log.delete();
        push_image(0);
        bus.img_ready = 1'b1;
        n = 0;
        while (addr_log.size() < 70 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("d_reach_read70", int'(addr_log.size() >= 70), 1);
        rel_before = rel_cnt;
        ready_mode = 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_clear("midreset");
        bus.img_ready = 1'b0;
        exp_addr.delete();
        exp_px.delete();
        px_in_img = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("d_no_release", rel_cnt, rel_before);
        repeat (2) @(posedge clk);
        #1;
        addr_log.delete();
        push_image(0);
        ready_mode = 2;
        bus.img_ready = 1'b1;
        wait_release(rel_before + 1, 3000);
        bus.img_ready = 1'b0;
        if (addr_log.size() > 0) check_eq("d_first_addr", addr_log[0], 0);
        check_eq("d_nreads", addr_log.size(), 144);
        check_eq("end_px_q_empty", exp_px.size(), 0);
        check_eq("end_addr_q_empty", exp_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_reader.md
CONV_WINDOW_READER -- requirements
Module: conv_window_reader

Interface
REQ-001 Parameters SHALL be: IMG_W 9 (image width), IMG_H 9 (image height), K 3 (kernel size), STRIDE 2 (window step), ADDR_W 8 (RAM address width), DATA_W 8 (pixel width).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 img_ready  input  1  high while the current ping-pong buffer holds a complete image (driven by the write-side counter).
REQ-005 img_release  output  1  one-cycle pulse when the current buffer has been fully consumed.
REQ-006 rAddr  output  ADDR_W  RAM read address.
REQ-007 rd_en  output  1  read issued this cycle.
REQ-008 ram_rdata  input  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
REQ-009 px_valid  output  1  px_data is valid.
REQ-010 px_ready  input  1  downstream accepts px_data when px_valid and px_ready are both high.
REQ-011 px_data  output  DATA_W  window pixel.
REQ-012 px_first  output  1  marks tap 0 of a window.
REQ-013 px_last  output  1  marks tap K*K-1 of a window.
REQ-014 px_img_last  output  1  marks the final tap of the final window of an image.

Function
REQ-015 Buffer base SHALL be 0 for buffer 0 and IMG_W*IMG_H (81) for buffer 1; a buf_sel bit SHALL start at 0 and toggle on each img_release.
REQ-016 Output grid SHALL be OUT_W = OUT_H = (IMG_W-K)/STRIDE+1 = 4, giving 16 windows and 144 reads per image.
REQ-017 Address SHALL be base + (orow*STRIDE+kr)*IMG_W + (ocol*STRIDE+kc), computed at ADDR_W width with no overflow for the default parameters.
REQ-018 Counter order SHALL be kc fastest, then kr, then ocol, then orow; each counter wraps to 0 at its limit.
REQ-019 FSM states SHALL be IDLE, READ, DRAIN and RELEASE.
REQ-020 IDLE -> READ SHALL occur when img_ready=1.
REQ-021 In READ, rd_en SHALL assert only when outstanding reads plus FIFO occupancy is less than 2.
REQ-022 READ -> DRAIN SHALL occur on the cycle the 144th read issues.
REQ-023 DRAIN -> RELEASE SHALL occur when the pixel carrying px_img_last is accepted.
REQ-024 RELEASE SHALL pulse img_release for 1 cycle, toggle buf_sel, clear all counters, then go to IDLE.
REQ-025 Read data SHALL enter a 2-entry output FIFO one cycle after rd_en, tagged with px_first, px_last and px_img_last.
REQ-026 Pixels SHALL never be dropped or duplicated under any px_ready pattern.
REQ-027 While px_valid=1 and px_ready=0, px_data and all tags SHALL hold stable.
REQ-028 Best-case throughput SHALL be 1 pixel per cycle when px_ready is held at 1.
REQ-029 Latency from the first rd_en to the first px_valid SHALL be 1 cycle.
REQ-030 If img_ready is already high in the cycle after RELEASE, the next image SHALL start with no idle gap beyond the IDLE cycle.
REQ-031 img_ready falling mid-image SHALL be ignored until RELEASE.

Reset
REQ-032 On reset, the FSM SHALL go to IDLE.
REQ-033 On reset, buf_sel and all counters SHALL be 0.
REQ-034 On reset, the FIFO SHALL be emptied.
REQ-035 On reset, rAddr=0, rd_en=0, px_valid=0, px_data=0, all tags=0 and img_release=0.
REQ-036 Reset mid-image SHALL discard in-flight reads and SHALL NOT pulse img_release.

Structure
REQ-037 Package conv_pkg SHALL hold IMG_W, IMG_H, K, STRIDE, ADDR_W, DATA_W, the derived OUT_W, OUT_H and BUF_DEPTH, and the FSM state enum.
REQ-038 The output FIFO SHALL be a separate sub-module, pixel_skid_fifo (2 entries, DATA_W+3 bits wide).

Verification
REQ-039 Buffer 0, px_ready=1: first window addresses SHALL be 0,1,2,9,10,11,18,19,20; last window SHALL be 60,61,62,69,70,71,78,79,80; there SHALL be 144 pixels, then one img_release pulse.
REQ-040 Second image: first address SHALL be 81, last address 161, and buf_sel SHALL return to 0 after release.
REQ-041 Random px_ready at 50%: the pixel sequence SHALL match a reference model exactly, with stable data while stalled and no drops or duplicates.
REQ-042 img_ready held high across two images: the 288 pixels SHALL be continuous and the two img_release pulses SHALL be separated by at least 144 cycles.
REQ-043 Reset asserted at read 70 of image 0 (px_ready held 0): all outputs SHALL clear; after re-arm, the first address SHALL be 0 and no img_release SHALL occur before 144 pixels.
REQ-044 Tags: px_first SHALL appear on pixels 0,9,18,...; px_last on pixels 8,17,...; px_img_last only on pixel 143.
